// File: rtl/hcms_serial_frame_tx.sv
// ---------------------------------------------------------------------------
// hcms_serial_frame_tx
//   Serial frame transmitter for HCMS-29xx dot-matrix displays, including
//   cascaded device chains. Words are accepted on a valid/ready stream. They
//   are grouped into frames delimited by s_last. Each frame is shifted out
//   MSB-first inside one n_ce window. reg_sel is latched from the first word
//   of the frame. The block also sequences the display hardware reset.
//
//   State | meaning
//   ------+--------------------------------------------------------------
//   HWRST | n_reset held low for RESET_CYCLES clocks
//   IDLE  | ready for the first word of a frame
//   SETUP | n_ce low, reg_sel settling before the first ser_clk fall
//   LOW   | ser_clk low, ser_data presents the current bit
//   HIGH  | ser_clk high, display samples on the rising edge
//   WAIT  | mid-frame stall, waiting for the next word
//   HOLD  | n_ce still low after the last rising edge
//   GAP   | n_ce high, minimum spacing before the next frame
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   s_valid/s_ready   word handshake; s_data word (MSB first), s_last ends
//                     the frame, s_cmd is the register select of the frame
//   disp_reset_req    one-cycle request for a display reset sequence
//   busy, frame_done  status: busy outside IDLE, pulse at end of frame
//   ser_data, ser_clk, reg_sel, n_ce, n_reset   display pins
// ---------------------------------------------------------------------------
module hcms_serial_frame_tx #(
  parameter int WORD_BITS    = 8,
  parameter int CLK_DIV      = 2,
  parameter int SETUP_CYCLES = 2,
  parameter int CE_HOLD      = 1,
  parameter int CE_GAP       = 2,
  parameter int RESET_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WORD_BITS-1:0] s_data,
  input  logic                 s_last,
  input  logic                 s_cmd,
  input  logic                 disp_reset_req,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 ser_data,
  output logic                 ser_clk,
  output logic                 reg_sel,
  output logic                 n_ce,
  output logic                 n_reset
);

  localparam int MAX_AB   = (CLK_DIV > SETUP_CYCLES) ? CLK_DIV : SETUP_CYCLES;
  localparam int MAX_CD   = (CE_HOLD > CE_GAP) ? CE_HOLD : CE_GAP;
  localparam int MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_ALL  = (MAX_ABCD > RESET_CYCLES) ? MAX_ABCD : RESET_CYCLES;
  localparam int PW       = $clog2(MAX_ALL + 1);
  localparam int BW       = $clog2(WORD_BITS);

  localparam logic [PW-1:0] LD_DIV   = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] LD_SETUP = PW'(SETUP_CYCLES - 1);
  localparam logic [PW-1:0] LD_HOLD  = PW'(CE_HOLD - 1);
  localparam logic [PW-1:0] LD_GAP   = PW'(CE_GAP - 1);
  localparam logic [PW-1:0] LD_RST   = PW'(RESET_CYCLES - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);

  localparam logic [2:0] ST_HWRST = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_HIGH  = 3'd4;
  localparam logic [2:0] ST_WAIT  = 3'd5;
  localparam logic [2:0] ST_HOLD  = 3'd6;
  localparam logic [2:0] ST_GAP   = 3'd7;

  logic [2:0]           state;
  logic [PW-1:0]        phase_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [WORD_BITS-1:0] shreg;
  logic                 last_q;
  logic                 reset_pend;

  logic hs;
  logic phase_tc;
  logic boundary_due;

  assign hs           = s_valid && s_ready;
  assign phase_tc     = (phase_cnt == '0);
  // Current bit is the last of a word and the frame continues: the next
  // word may be taken in the final clock of this bit's HIGH phase.
  assign boundary_due = (bit_cnt == LAST_BIT) && !last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_HWRST;
      phase_cnt  <= LD_RST;
      bit_cnt    <= '0;
      shreg      <= '0;
      last_q     <= 1'b0;
      reset_pend <= 1'b0;
      s_ready    <= 1'b0;
      busy       <= 1'b1;
      frame_done <= 1'b0;
      ser_data   <= 1'b0;
      ser_clk    <= 1'b1;
      reg_sel    <= 1'b0;
      n_ce       <= 1'b1;
      n_reset    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (disp_reset_req && state != ST_IDLE)
        reset_pend <= 1'b1;

      case (state)
        ST_HWRST: begin
          if (phase_tc) begin
            n_reset <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
            // A request that arrives meanwhile keeps the stream closed so
            // the next IDLE cycle can service it.
            s_ready <= !(reset_pend || disp_reset_req);
          end else begin
            phase_cnt <= phase_cnt - PW'(1);
          end
        end

        ST_IDLE: begin
          if (reset_pend || (disp_reset_req && !hs)) begin
            reset_pend <= 1'b0;
            n_reset    <= 1'b0;
            busy       <= 1'b1;
            s_ready    <= 1'b0;
            phase_cnt  <= LD_RST;
            state      <= ST_HWRST;
          end else if (hs) begin
            // A request coinciding with an accepted word waits for the frame.
            if (disp_reset_req)
              reset_pend <= 1'b1;
            shreg     <= s_data;
            last_q    <= s_last;
            bit_cnt   <= '0;
            reg_sel   <= s_cmd;
            n_ce      <= 1'b0;
            busy      <= 1'b1;
            s_ready   <= 1'b0;
            phase_cnt <= LD_SETUP;
            state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (phase_tc) begin
            ser_clk   <= 1'b0;
            ser_data  <= shreg[WORD_BITS-1];
            phase_cnt <= LD_DIV;
            state     <= ST_LOW;
          end else begin
            phase_cnt <= phase_cnt - PW'(1);
          end
        end

        ST_LOW: begin
          if (phase_tc) begin
            ser_clk   <= 1'b1;
            phase_cnt <= LD_DIV;
            state     <= ST_HIGH;
            // With a one-clock HIGH phase the boundary clock is its first.
            s_ready   <= (CLK_DIV == 1) && boundary_due;
          end else begin
            phase_cnt <= phase_cnt - PW'(1);
          end
        end

        ST_HIGH: begin
          if (!phase_tc) begin
            phase_cnt <= phase_cnt - PW'(1);
            if (phase_cnt == PW'(1) && boundary_due)
              s_ready <= 1'b1;
          end else begin
            s_ready <= 1'b0;
            if (bit_cnt != LAST_BIT) begin
              shreg     <= {shreg[WORD_BITS-2:0], 1'b0};
              ser_data  <= shreg[WORD_BITS-2];
              bit_cnt   <= bit_cnt + BW'(1);
              ser_clk   <= 1'b0;
              phase_cnt <= LD_DIV;
              state     <= ST_LOW;
            end else if (last_q) begin
              phase_cnt <= LD_HOLD;
              state     <= ST_HOLD;
            end else if (hs) begin
              shreg     <= s_data;
              ser_data  <= s_data[WORD_BITS-1];
              last_q    <= s_last;
              bit_cnt   <= '0;
              ser_clk   <= 1'b0;
              phase_cnt <= LD_DIV;
              state     <= ST_LOW;
            end else begin
              s_ready <= 1'b1;
              state   <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (s_valid) begin
            shreg     <= s_data;
            ser_data  <= s_data[WORD_BITS-1];
            last_q    <= s_last;
            bit_cnt   <= '0;
            ser_clk   <= 1'b0;
            s_ready   <= 1'b0;
            phase_cnt <= LD_DIV;
            state     <= ST_LOW;
          end
        end

        ST_HOLD: begin
          if (phase_tc) begin
            n_ce       <= 1'b1;
            frame_done <= 1'b1;
            phase_cnt  <= LD_GAP;
            state      <= ST_GAP;
          end else begin
            phase_cnt <= phase_cnt - PW'(1);
          end
        end

        ST_GAP: begin
          if (phase_tc) begin
            busy    <= 1'b0;
            s_ready <= !(reset_pend || disp_reset_req);
            state   <= ST_IDLE;
          end else begin
            phase_cnt <= phase_cnt - PW'(1);
          end
        end

        default: begin
          n_reset   <= 1'b0;
          n_ce      <= 1'b1;
          ser_clk   <= 1'b1;
          busy      <= 1'b1;
          s_ready   <= 1'b0;
          phase_cnt <= LD_RST;
          state     <= ST_HWRST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hcms_serial_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_hcms_serial_frame_tx
//   Directed bench for hcms_serial_frame_tx. One instance with the default
//   parameters and one with CLK_DIV=1. A passive monitor records pin
//   activity; the directed sequence compares it with hand-computed values.
// ---------------------------------------------------------------------------
module tb_hcms_serial_frame_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid, s_last, s_cmd, disp_reset_req;
  logic [7:0] s_data;
  logic       s_ready, busy, frame_done, ser_data, ser_clk, reg_sel, n_ce, n_reset;

  logic       s_valid1, s_last1, s_cmd1, disp_reset_req1;
  logic [7:0] s_data1;
  logic       s_ready1, busy1, frame_done1, ser_data1, ser_clk1, reg_sel1, n_ce1, n_reset1;

  always #5 clk = ~clk;

  hcms_serial_frame_tx dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .s_cmd(s_cmd),
    .disp_reset_req(disp_reset_req), .busy(busy), .frame_done(frame_done),
    .ser_data(ser_data), .ser_clk(ser_clk), .reg_sel(reg_sel),
    .n_ce(n_ce), .n_reset(n_reset)
  );

  hcms_serial_frame_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .s_valid(s_valid1), .s_ready(s_ready1),
    .s_data(s_data1), .s_last(s_last1), .s_cmd(s_cmd1),
    .disp_reset_req(disp_reset_req1), .busy(busy1), .frame_done(frame_done1),
    .ser_data(ser_data1), .ser_clk(ser_clk1), .reg_sel(reg_sel1),
    .n_ce(n_ce1), .n_reset(n_reset1)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- monitor ----------------
  int   cyc = 0;
  logic bitq[$];
  int   fallq[$];
  int   nce_fall = 0, nce_rises = 0, nce_low = 0, fd_cnt = 0, fd_cyc = 0, nres_falls = 0;
  logic pclk = 1'b1, pnce = 1'b1, pnres = 1'b0;
  logic bitq1[$];
  int   fallq1[$];
  int   nce_low1 = 0, fd_cnt1 = 0, fd_cyc1 = 0;
  logic pclk1 = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ser_clk && !pclk) bitq.push_back(ser_data);
    if (!ser_clk && pclk) fallq.push_back(cyc);
    if (!n_ce && pnce) nce_fall <= cyc;
    if (n_ce && !pnce) nce_rises <= nce_rises + 1;
    if (!n_ce) nce_low <= nce_low + 1;
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_cyc <= cyc;
    end
    if (!n_reset && pnres) nres_falls <= nres_falls + 1;
    pclk  <= ser_clk;
    pnce  <= n_ce;
    pnres <= n_reset;
    if (ser_clk1 && !pclk1) bitq1.push_back(ser_data1);
    if (!ser_clk1 && pclk1) fallq1.push_back(cyc);
    if (!n_ce1) nce_low1 <= nce_low1 + 1;
    if (frame_done1) begin
      fd_cnt1 <= fd_cnt1 + 1;
      fd_cyc1 <= cyc;
    end
    pclk1 <= ser_clk1;
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  int hs_cyc;

  task automatic push_word(input logic [7:0] d, input logic l, input logic c, input string tag);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    s_cmd   = c;
    for (int i = 0; i < 300 && s_ready !== 1'b1; i++) step();
    if (s_ready !== 1'b1) timeout(tag);
    hs_cyc = cyc;
    step();
  endtask

  task automatic wait_fd(input int base, input string tag);
    for (int i = 0; i < 600 && fd_cnt == base; i++) step();
    if (fd_cnt == base) timeout(tag);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && !(s_ready === 1'b1 && s_ready1 === 1'b1); i++) step();
    if (!(s_ready === 1'b1 && s_ready1 === 1'b1)) timeout(tag);
  endtask

  function automatic logic [23:0] bits_from(input int b, input int n);
    logic [23:0] acc = '0;
    for (int i = 0; i < n; i++) acc = {acc[22:0], bitq[b + i]};
    return acc;
  endfunction

  // ---------------- directed sequence ----------------
  int bb, fb, fdb, ncl, ncr, nrf, cnt, bad, c0;
  logic [7:0] acc1;

  initial begin
    reset = 1'b1;
    s_valid = 0; s_data = 0; s_last = 0; s_cmd = 0; disp_reset_req = 0;
    s_valid1 = 0; s_data1 = 0; s_last1 = 0; s_cmd1 = 0; disp_reset_req1 = 0;
    step(); step(); step();

    // 1: reset values and hardware reset sequence
    chk("rst_n_reset", n_reset, 1'b0);
    chk("rst_ser_clk", ser_clk, 1'b1);
    chk("rst_n_ce", n_ce, 1'b1);
    chk("rst_busy", busy, 1'b1);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    reset = 1'b0;
    cnt = 1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (ser_clk !== 1'b1 || n_ce !== 1'b1) bad++;
      if (n_reset === 1'b0) cnt++;
      else break;
    end
    chk("hwrst_low_clocks", cnt, 16);
    chk("hwrst_pins_high", bad, 0);
    chk("idle_s_ready", s_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // 2: single word 0xA5, control register
    bb = bitq.size(); fb = fallq.size(); fdb = fd_cnt; ncl = nce_low;
    push_word(8'hA5, 1'b1, 1'b1, "t2_hs");
    c0 = hs_cyc;
    s_valid = 1'b0;
    wait_fd(fdb, "t2_frame_done");
    chk("t2_reg_sel", reg_sel, 1'b1);
    chk("t2_bit_count", bitq.size() - bb, 8);
    chk("t2_bits", bits_from(bb, 8), 24'h0000A5);
    chk("t2_setup_to_fall", fallq[fb] - nce_fall, 2);
    chk("t2_fall_spacing", fallq[fb + 7] - fallq[fb], 28);
    chk("t2_hs_to_done", fd_cyc - c0, 36);
    chk("t2_nce_low", nce_low - ncl, 35);
    step(); step();
    chk("t2_done_once", fd_cnt - fdb, 1);
    chk("t2_nce_high", n_ce, 1'b1);
    wait_idle("t2_idle");

    // 3: three streamed words, s_cmd toggling
    bb = bitq.size(); fb = fallq.size(); fdb = fd_cnt; ncl = nce_low; ncr = nce_rises;
    push_word(8'h01, 1'b0, 1'b0, "t3_w0");
    push_word(8'hFF, 1'b0, 1'b1, "t3_w1");
    chk("t3_reg_sel_mid", reg_sel, 1'b0);
    push_word(8'h80, 1'b1, 1'b0, "t3_w2");
    s_valid = 1'b0;
    wait_fd(fdb, "t3_frame_done");
    step(); step();
    chk("t3_bits", bits_from(bb, 24), 24'h01FF80);
    chk("t3_falls", fallq.size() - fb, 24);
    chk("t3_contiguous", fallq[fb + 23] - fallq[fb], 92);
    chk("t3_nce_low", nce_low - ncl, 99);
    chk("t3_windows", nce_rises - ncr, 1);
    chk("t3_done_once", fd_cnt - fdb, 1);
    chk("t3_reg_sel", reg_sel, 1'b0);
    wait_idle("t3_idle");

    // 4: stall of 10 clocks after word 1
    bb = bitq.size(); fdb = fd_cnt; ncl = nce_low; ncr = nce_rises;
    push_word(8'h01, 1'b0, 1'b1, "t4_w0");
    s_valid = 1'b0;
    for (int i = 0; i < 200 && s_ready !== 1'b1; i++) step();
    if (s_ready !== 1'b1) timeout("t4_boundary");
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_ready === 1'b1 && ser_clk === 1'b1 && n_ce === 1'b0) cnt++;
    end
    chk("t4_wait_clocks", cnt, 10);
    push_word(8'hFF, 1'b0, 1'b0, "t4_w1");
    push_word(8'h80, 1'b1, 1'b0, "t4_w2");
    s_valid = 1'b0;
    wait_fd(fdb, "t4_frame_done");
    step();
    chk("t4_bits", bits_from(bb, 24), 24'h01FF80);
    chk("t4_nce_low", nce_low - ncl, 109);
    chk("t4_windows", nce_rises - ncr, 1);
    chk("t4_reg_sel", reg_sel, 1'b1);
    wait_idle("t4_idle");

    // 5: two reset requests during a frame give one deferred reset sequence
    bb = bitq.size(); fdb = fd_cnt; nrf = nres_falls;
    push_word(8'h3C, 1'b0, 1'b0, "t5_w0");
    push_word(8'hC3, 1'b0, 1'b0, "t5_w1");
    disp_reset_req = 1'b1;
    step();
    disp_reset_req = 1'b0;
    step(); step(); step(); step(); step();
    disp_reset_req = 1'b1;
    step();
    disp_reset_req = 1'b0;
    push_word(8'h5A, 1'b1, 1'b0, "t5_w2");
    s_valid = 1'b0;
    wait_fd(fdb, "t5_frame_done");
    chk("t5_bits", bits_from(bb, 24), 24'h3CC35A);
    chk("t5_n_reset_in_frame", nres_falls - nrf, 0);
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (n_reset === 1'b1 && cnt > 0) break;
      if (s_ready !== 1'b0) bad++;
      if (n_reset === 1'b0) cnt++;
    end
    chk("t5_reset_low_clocks", cnt, 16);
    chk("t5_ready_held_low", bad, 0);
    chk("t5_ready_after", s_ready, 1'b1);
    for (int i = 0; i < 30; i++) step();
    chk("t5_one_sequence", nres_falls - nrf, 1);
    chk("t5_done_once", fd_cnt - fdb, 1);

    // 6: reset during bit 4
    fb = fallq.size(); fdb = fd_cnt;
    push_word(8'hFF, 1'b1, 1'b0, "t6_w0");
    s_valid = 1'b0;
    for (int i = 0; i < 100 && fallq.size() < fb + 5; i++) step();
    if (fallq.size() < fb + 5) timeout("t6_bit4");
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_n_ce", n_ce, 1'b1);
    chk("t6_ser_clk", ser_clk, 1'b1);
    chk("t6_n_reset", n_reset, 1'b0);
    chk("t6_busy", busy, 1'b1);
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (n_reset === 1'b0) cnt++;
      else break;
    end
    chk("t6_hwrst_clocks", cnt, 16);
    for (int i = 0; i < 20; i++) step();
    chk("t6_no_frame_done", fd_cnt - fdb, 0);
    wait_idle("t6_idle");

    // CLK_DIV=1 instance, single word 0xA5
    bb = bitq1.size(); fb = fallq1.size(); fdb = fd_cnt1; ncl = nce_low1;
    s_valid1 = 1'b1; s_data1 = 8'hA5; s_last1 = 1'b1; s_cmd1 = 1'b0;
    c0 = cyc;
    step();
    s_valid1 = 1'b0;
    for (int i = 0; i < 200 && fd_cnt1 == fdb; i++) step();
    if (fd_cnt1 == fdb) timeout("d1_frame_done");
    acc1 = '0;
    for (int i = 0; i < 8; i++) acc1 = {acc1[6:0], bitq1[bb + i]};
    chk("d1_bits", acc1, 8'hA5);
    chk("d1_hs_to_done", fd_cyc1 - c0, 20);
    chk("d1_fall_spacing", fallq1[fb + 7] - fallq1[fb], 14);
    chk("d1_nce_low", nce_low1 - ncl, 19);
    chk("d1_reg_sel", reg_sel1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
